ptr_refcnt_release: RTL and testbench

// - Return side of the shared-buffer free pointer queue: decides when a frame buffer pointer goes back to the free queue.
// - Keeps a per-pointer reference count (fan-out) for multicast frames.
// - Decrements the count on each egress-port release; when it reaches zero, pulses FQ_wr with the pointer on ptr_dout (wired to the free queue's FQ_wr/ptr_din).

---
 rtl/tsn_buf_pkg.sv | 22 ++
 rtl/refcnt_ram.sv | 31 +++
 rtl/ptr_refcnt_release.sv | 254 +++++++++++++++++++++++++
 tb/tb_ptr_refcnt_release.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsn_buf_pkg.sv
// Shared definitions for the frame-buffer pointer blocks: default pointer,
// count and port widths, plus the operation and FSM state encodings used by
// the reference-count release pipeline.
package tsn_buf_pkg;

    localparam int DEF_PTR_W     = 9;
    localparam int DEF_CNT_W     = 3;
    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_DEPTH     = 1 << DEF_PTR_W;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_ALLOC = 2'd1,
        OP_REL   = 2'd2
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/refcnt_ram.sv
// Reference-count storage: simple dual-port RAM, one write port and one
// synchronous read port with a single cycle of latency. A read and a write to
// the same address on the same edge return the old contents; the parent
// pipeline forwards in-flight values so that ordering never matters here.
module refcnt_ram #(
    parameter int AW = 9,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Write port: store a new count when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: registered read of the addressed count
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/ptr_refcnt_release.sv
// Free-pointer return path. Tracks a reference count per buffer pointer,
// decrements it on each egress-port release and hands the pointer back to the
// free queue (FQ_wr / ptr_dout) when the count reaches zero.
// Pipeline: S0 arbitrate (alloc beats releases, releases round-robin),
// S1 read count with forwarding, S2 write count; FQ_wr is registered at the
// end of S1 so it appears during S2, two cycles after rel_ack.
// Optional build macro REFCNT_STATS_EN adds stat_rel_cnt / stat_free_cnt.
module ptr_refcnt_release
    import tsn_buf_pkg::*;
#(
    parameter int PTR_W     = DEF_PTR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    input  logic [PTR_W-1:0]           alloc_ptr,
    input  logic [CNT_W-1:0]           alloc_fanout,
    input  logic [NUM_PORTS-1:0]       rel_req,
    input  logic [NUM_PORTS*PTR_W-1:0] rel_ptr,
    output logic [NUM_PORTS-1:0]       rel_ack,
    output logic                       FQ_wr,
    output logic [PTR_W-1:0]           ptr_dout,
    output logic                       init_done,
    output logic                       err_underflow
`ifdef REFCNT_STATS_EN
    ,
    output logic [31:0]                stat_rel_cnt,
    output logic [31:0]                stat_free_cnt
`endif
);

    localparam int DEPTH  = 1 << PTR_W;
    localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                 state_r;
    logic [PTR_W-1:0]       init_idx_r;
    logic [PIDX_W-1:0]      rr_ptr_r;

    // S0 arbitration results
    logic                   arb_en_s;
    logic                   alloc_s;
    logic                   found_s;
    logic [PIDX_W-1:0]      grant_idx_s;
    logic [NUM_PORTS-1:0]   grant_s;
    int                     cand_s;
    op_e                    s0_op_s;
    logic [PTR_W-1:0]       s0_ptr_s;

    // S1 stage
    op_e                    s1_op_r;
    logic [PTR_W-1:0]       s1_ptr_r;
    logic [CNT_W-1:0]       s1_fan_r;
    logic [CNT_W-1:0]       ram_rdata_s;
    logic [CNT_W-1:0]       fwd_cnt_s;
    logic                   s1_we_s;
    logic [CNT_W-1:0]       s1_new_s;
    logic                   s1_free_s;
    logic                   s1_under_s;

    // S2 stage (pending RAM write) and the write retired on the previous edge
    logic                   s2_we_r;
    logic [PTR_W-1:0]       s2_ptr_r;
    logic [CNT_W-1:0]       s2_cnt_r;
    logic                   w_we_r;
    logic [PTR_W-1:0]       w_ptr_r;
    logic [CNT_W-1:0]       w_cnt_r;

    // RAM port muxing
    logic                   ram_we_s;
    logic [PTR_W-1:0]       ram_waddr_s;
    logic [CNT_W-1:0]       ram_wdata_s;

    assign arb_en_s = reset && (state_r == ST_RUN) && !alloc_valid;
    assign alloc_s  = reset && (state_r == ST_RUN) && alloc_valid;
    assign rel_ack  = grant_s;

    // Round-robin search starting one past the previous grant
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        grant_s     = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = (int'(rr_ptr_r) + k) % NUM_PORTS;
            if (arb_en_s && !found_s && rel_req[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = PIDX_W'(cand_s);
            end else begin
                found_s     = found_s;
            end
        end
        grant_s[grant_idx_s] = found_s;
    end

    // Select the S0 operation and the pointer whose count is read this cycle
    always_comb begin
        if (alloc_s) begin
            s0_op_s  = OP_ALLOC;
            s0_ptr_s = alloc_ptr;
        end else if (found_s) begin
            s0_op_s  = OP_REL;
            s0_ptr_s = rel_ptr[int'(grant_idx_s)*PTR_W +: PTR_W];
        end else begin
            s0_op_s  = OP_NONE;
            s0_ptr_s = alloc_ptr;
        end
    end

    // Forward counts not yet visible in the RAM read data (newest first)
    always_comb begin
        if (s2_we_r && (s2_ptr_r == s1_ptr_r)) begin
            fwd_cnt_s = s2_cnt_r;
        end else if (w_we_r && (w_ptr_r == s1_ptr_r)) begin
            fwd_cnt_s = w_cnt_r;
        end else begin
            fwd_cnt_s = ram_rdata_s;
        end
    end

    // S1 decision: new count, free-queue return and underflow detection
    always_comb begin
        s1_we_s    = 1'b0;
        s1_new_s   = fwd_cnt_s;
        s1_free_s  = 1'b0;
        s1_under_s = 1'b0;
        case (s1_op_r)
            OP_ALLOC: begin
                s1_we_s   = 1'b1;
                s1_new_s  = s1_fan_r;
                s1_free_s = (s1_fan_r == {CNT_W{1'b0}});
            end
            OP_REL: begin
                if (fwd_cnt_s == {CNT_W{1'b0}}) begin
                    s1_under_s = 1'b1;
                end else begin
                    s1_we_s   = 1'b1;
                    s1_new_s  = fwd_cnt_s - CNT_W'(1);
                    s1_free_s = (fwd_cnt_s == CNT_W'(1));
                end
            end
            default: begin
                s1_we_s = 1'b0;
            end
        endcase
    end

    // RAM write source: clearing sweep during INIT, S2 update during RUN
    always_comb begin
        if (state_r == ST_INIT) begin
            ram_we_s    = reset;
            ram_waddr_s = init_idx_r;
            ram_wdata_s = {CNT_W{1'b0}};
        end else begin
            ram_we_s    = reset && s2_we_r;
            ram_waddr_s = s2_ptr_r;
            ram_wdata_s = s2_cnt_r;
        end
    end

    // FSM, arbiter pointer, pipeline registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_INIT;
            init_idx_r    <= '0;
            init_done     <= 1'b0;
            rr_ptr_r      <= '0;
            s1_op_r       <= OP_NONE;
            s1_ptr_r      <= '0;
            s1_fan_r      <= '0;
            s2_we_r       <= 1'b0;
            s2_ptr_r      <= '0;
            s2_cnt_r      <= '0;
            w_we_r        <= 1'b0;
            w_ptr_r       <= '0;
            w_cnt_r       <= '0;
            FQ_wr         <= 1'b0;
            ptr_dout      <= '0;
            err_underflow <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_idx_r <= init_idx_r + PTR_W'(1);
                    if (init_idx_r == PTR_W'(DEPTH - 1)) begin
                        state_r   <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state_r   <= ST_INIT;
                    init_done <= 1'b0;
                end
            endcase

            if (found_s) begin
                rr_ptr_r <= (int'(grant_idx_s) == NUM_PORTS - 1) ? '0
                                                                 : grant_idx_s + PIDX_W'(1);
            end

            s1_op_r  <= s0_op_s;
            s1_ptr_r <= s0_ptr_s;
            s1_fan_r <= alloc_fanout;

            s2_we_r  <= s1_we_s;
            s2_ptr_r <= s1_ptr_r;
            s2_cnt_r <= s1_new_s;

            w_we_r   <= s2_we_r;
            w_ptr_r  <= s2_ptr_r;
            w_cnt_r  <= s2_cnt_r;

            FQ_wr    <= s1_free_s;
            ptr_dout <= s1_free_s ? s1_ptr_r : '0;

            if (s1_under_s) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef REFCNT_STATS_EN
    // Activity counters: accepted releases and pointers returned
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_rel_cnt  <= 32'd0;
            stat_free_cnt <= 32'd0;
        end else begin
            if (found_s) begin
                stat_rel_cnt <= stat_rel_cnt + 32'd1;
            end
            if (FQ_wr) begin
                stat_free_cnt <= stat_free_cnt + 32'd1;
            end
        end
    end
`endif

    refcnt_ram #(
        .AW (PTR_W),
        .DW (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (s0_ptr_s),
        .rdata (ram_rdata_s)
    );

endmodule

// File: tb/tb_ptr_refcnt_release.sv
// Directed bench for ptr_refcnt_release: a reference model of the counts and
// round-robin arbiter predicts grants; expected free-queue returns go into a
// scoreboard queue with their due cycle and are checked by a monitor.
module tb_ptr_refcnt_release;

    localparam int PTR_W = 9;
    localparam int NP    = 4;
    localparam int CNT_W = 3;
    localparam int DEPTH = 512;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  alloc_valid;
    logic [PTR_W-1:0]      alloc_ptr;
    logic [CNT_W-1:0]      alloc_fanout;
    logic [NP-1:0]         rel_req;
    logic [NP*PTR_W-1:0]   rel_ptr;
    logic [NP-1:0]         rel_ack;
    logic                  FQ_wr;
    logic [PTR_W-1:0]      ptr_dout;
    logic                  init_done;
    logic                  err_underflow;

    typedef struct {
        logic [PTR_W-1:0] ptr;
        int               due;
    } exp_t;

    exp_t             sb[$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               cnt_m[DEPTH];
    logic [NP-1:0]    req_m;
    logic [PTR_W-1:0] relp_m[NP];
    int               rr_m;

    ptr_refcnt_release dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_ptr     (alloc_ptr),
        .alloc_fanout  (alloc_fanout),
        .rel_req       (rel_req),
        .rel_ptr       (rel_ptr),
        .rel_ack       (rel_ack),
        .FQ_wr         (FQ_wr),
        .ptr_dout      (ptr_dout),
        .init_done     (init_done),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Free-queue monitor: FQ_wr must fire exactly on scoreboard due cycles
    always @(negedge clk) begin : mon
        logic fire;
        fire = (sb.size() != 0) && (sb[0].due == cyc);
        chk("fq_wr", {31'd0, FQ_wr}, {31'd0, fire});
        if (fire) begin
            chk("fq_ptr", {23'd0, ptr_dout}, {23'd0, sb[0].ptr});
            void'(sb.pop_front());
        end
    end

    function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] req, input int start);
        logic [NP-1:0] g;
        g = '0;
        for (int k = 0; k < NP; k++) begin
            if (g == '0 && req[(start + k) % NP]) g[(start + k) % NP] = 1'b1;
        end
        return g;
    endfunction

    task automatic drive_ptrs();
        for (int p = 0; p < NP; p++) rel_ptr[p*PTR_W +: PTR_W] = relp_m[p];
    endtask

    task automatic wait_init();
        @(negedge clk);
        for (int p = 0; p < NP; p++) relp_m[p] = 9'h001;
        drive_ptrs();
        rel_req      = 4'hF;
        alloc_valid  = 1'b1;
        alloc_ptr    = 9'h0AA;
        alloc_fanout = 3'd0;
        reset        = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            @(posedge clk); #1;
            chk("init_phase", {27'd0, init_done, rel_ack}, 32'd0);
        end
        @(negedge clk);
        rel_req     = 4'h0;
        alloc_valid = 1'b0;
        @(posedge clk); #1;
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        for (int i = 0; i < DEPTH; i++) cnt_m[i] = 0;
        rr_m = 0;
    endtask

    task automatic do_alloc(input logic [PTR_W-1:0] p, input int fan);
        @(negedge clk);
        rel_req      = 4'h0;
        alloc_valid  = 1'b1;
        alloc_ptr    = p;
        alloc_fanout = CNT_W'(fan);
        cnt_m[p]     = fan;
        if (fan == 0) sb.push_back('{ptr: p, due: cyc + 2});
    endtask

    task automatic run_rel(input int budget);
        logic [NP-1:0] g;
        int            n;
        int            pi;
        logic [PTR_W-1:0] p;
        n = 0;
        while (req_m != '0 && n < budget) begin
            @(negedge clk);
            alloc_valid = 1'b0;
            drive_ptrs();
            rel_req = req_m;
            #1;
            g = rr_pick(req_m, rr_m);
            chk("rel_ack", {28'd0, rel_ack}, {28'd0, g});
            if (g != '0) begin
                pi = 0;
                for (int k = 0; k < NP; k++) if (g[k]) pi = k;
                p = relp_m[pi];
                if (cnt_m[p] != 0) begin
                    cnt_m[p] = cnt_m[p] - 1;
                    if (cnt_m[p] == 0) sb.push_back('{ptr: p, due: cyc + 2});
                end
                req_m = req_m & ~g;
                rr_m  = (pi + 1) % NP;
            end
            n++;
        end
        chk("rel_budget", {28'd0, req_m}, 32'd0);
        req_m = '0;
        @(negedge clk);
        rel_req     = 4'h0;
        alloc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rel_req     = 4'h0;
            alloc_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_ptr    = '0;
        alloc_fanout = '0;
        rel_req      = '0;
        rel_ptr      = '0;
        req_m        = '0;
        rr_m         = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {25'd0, rel_ack, FQ_wr, init_done, err_underflow}, 32'd0);

        wait_init();

        // Fan-out 3, three ports release back-to-back behind the alloc
        do_alloc(9'h005, 3);
        relp_m[0] = 9'h005; relp_m[1] = 9'h005; relp_m[2] = 9'h005;
        req_m = 4'b0111;
        run_rel(10);
        idle(3);

        // Fan-out 0 returns immediately
        do_alloc(9'h1FE, 0);
        idle(4);

        // All ports contend for one pointer with fan-out 4
        do_alloc(9'h010, 4);
        for (int p = 0; p < NP; p++) relp_m[p] = 9'h010;
        req_m = 4'hF;
        run_rel(10);
        idle(3);

        // Alloc wins over a pending release in the same cycle
        do_alloc(9'h030, 1);
        @(negedge clk);
        relp_m[2] = 9'h030;
        drive_ptrs();
        req_m        = 4'b0100;
        rel_req      = req_m;
        alloc_valid  = 1'b1;
        alloc_ptr    = 9'h031;
        alloc_fanout = 3'd0;
        cnt_m[9'h031] = 0;
        sb.push_back('{ptr: 9'h031, due: cyc + 2});
        #1;
        chk("alloc_priority", {28'd0, rel_ack}, 32'd0);
        run_rel(8);
        idle(3);
        chk("no_underflow_yet", {31'd0, err_underflow}, 32'd0);

        // Release of a never-allocated pointer underflows, sticky
        relp_m[1] = 9'h020;
        req_m = 4'b0010;
        run_rel(8);
        idle(3);
        chk("underflow_set", {31'd0, err_underflow}, 32'd1);

        // Zero fan-out left the count at 0: releasing it must not return it
        relp_m[3] = 9'h1FE;
        req_m = 4'b1000;
        run_rel(8);
        do_alloc(9'h050, 2);
        relp_m[0] = 9'h050; relp_m[3] = 9'h050;
        req_m = 4'b1001;
        run_rel(8);
        idle(4);
        chk("underflow_sticky", {31'd0, err_underflow}, 32'd1);

        // Reset while a return is one cycle from FQ_wr
        @(negedge clk);
        alloc_valid  = 1'b1;
        alloc_ptr    = 9'h040;
        alloc_fanout = 3'd0;
        @(negedge clk);
        alloc_valid = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_clears", {29'd0, FQ_wr, init_done, err_underflow}, 32'd0);

        wait_init();

        // Counts were cleared by the re-init sweep
        relp_m[0] = 9'h005;
        req_m = 4'b0001;
        run_rel(8);
        idle(4);
        chk("underflow_after_reinit", {31'd0, err_underflow}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
